// File: rtl/io_bridge.sv
// io_bridge: CPU bus bridge. Non-IO accesses go straight through to an external RAM.
// IO accesses reach a UART TX FIFO, the UART RX byte, a stop/drain control register
// and a 32-bit cycle counter that is read through a snapshot latch.
module io_bridge #(
   parameter int unsigned TX_DEPTH = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] cpu_a,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_wr,
   output logic [7:0]  cpu_din,
   output logic        io_buffer_full,
   output logic [16:0] ram_a,
   output logic        ram_we,
   output logic [7:0]  ram_dout,
   input  logic [7:0]  ram_din,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        prog_done
);

   localparam int unsigned PtrW = $clog2(TX_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   localparam logic [17:0] AddrTx      = 18'h30000;
   localparam logic [17:0] AddrStop    = 18'h30004;
   // 0x30004..0x30007 share this word address
   localparam logic [15:0] AddrCntWord = 16'hC001;

   typedef enum logic [1:0] {StRun, StStopDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic [7:0]        mem_q [TX_DEPTH];
   logic [PtrW-1:0]   wptr_q, rptr_q;
   logic [CntW-1:0]   count_q, count_d;
   logic [31:0]       cyc_q;
   logic [31:0]       latch_q, latch_d;
   logic [7:0]        io_rdata_q, io_rdata_d;
   logic              sel_io_q;
   logic              full_q;
   logic              prev_vld_q;
   logic [31:0]       prev_a_q;
   logic              prev_wr_q;

   logic              io_sel, new_acc, io_new;
   logic              wr_tx, wr_stop, rd_rx, rd_snap;
   logic              pop, push, can_push, drain_empty;
   logic [7:0]        push_data;
   logic [31:0]       snap_src;

   assign io_sel  = (cpu_a[17:16] == 2'b11);
   // Side effects fire only on the first cycle of a differing address/direction pair
   assign new_acc = ~prev_vld_q | (cpu_a != prev_a_q) | (cpu_wr != prev_wr_q);
   assign io_new  = io_sel & new_acc;

   assign wr_tx   = io_new &  cpu_wr & (cpu_a[17:0] == AddrTx);
   assign wr_stop = io_new &  cpu_wr & (cpu_a[17:0] == AddrStop);
   assign rd_rx   = io_new & ~cpu_wr & (cpu_a[17:0] == AddrTx);
   assign rd_snap = io_new & ~cpu_wr & (cpu_a[17:0] == AddrStop);

   assign ram_a    = cpu_a[16:0];
   assign ram_dout = cpu_dout;
   assign ram_we   = cpu_wr & ~io_sel;

   assign tx_valid = (count_q != '0);
   assign tx_data  = mem_q[rptr_q];
   assign pop      = tx_valid & tx_ready;
   // A full FIFO still accepts a byte when the head leaves in the same cycle
   assign can_push = (count_q != CntW'(TX_DEPTH)) | pop;
   // FIFO will be empty after this edge (nothing can be pushed while draining)
   assign drain_empty = (count_q == '0) | ((count_q == CntW'(1)) & pop);

   assign rx_pop         = rd_rx & rx_valid & ~rst_in;
   assign io_buffer_full = full_q;
   assign prog_done      = (state_q == StDone);
   assign cpu_din        = sel_io_q ? io_rdata_q : ram_din;

   // Control FSM: decides pushes into the TX FIFO and the stop/drain sequence
   always_comb begin
      state_d   = state_q;
      push      = 1'b0;
      push_data = cpu_dout;
      unique case (state_q)
         StRun: begin
            if (wr_tx) begin
               push = (cpu_dout != 8'h00) & can_push;
            end else if (wr_stop) begin
               push      = can_push;
               push_data = 8'h00;
               state_d   = StStopDrain;
            end
         end
         StStopDrain: begin
            if (drain_empty) state_d = StDone;
         end
         StDone: begin
            state_d = StDone;
         end
         default: state_d = StRun;
      endcase
   end

   // FIFO occupancy after this cycle's push/pop
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CntW'(1);
      end
   end

   // IO read data and counter snapshot
   always_comb begin
      io_rdata_d = 8'h00;
      latch_d    = rd_snap ? cyc_q : latch_q;
      // A fresh 0x30004 read returns the value being latched, so the first byte matches
      snap_src   = rd_snap ? cyc_q : latch_q;
      if (io_sel && !cpu_wr) begin
         if (rd_rx && rx_valid) begin
            io_rdata_d = rx_data;
         end else if (cpu_a[17:2] == AddrCntWord) begin
            io_rdata_d = snap_src[{cpu_a[1:0], 3'b000} +: 8];
         end
      end
   end

   // FIFO storage; contents need no reset since count gates visibility
   always_ff @(posedge clk_in) begin
      if (push) mem_q[wptr_q] <= push_data;
   end

   // State, pointers, counter, read pipeline and access-tracking registers
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= StRun;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         cyc_q      <= 32'h0;
         latch_q    <= 32'h0;
         io_rdata_q <= 8'h00;
         sel_io_q   <= 1'b1;  // selects the zeroed IO data so cpu_din reads 0x00
         full_q     <= 1'b0;
         prev_vld_q <= 1'b0;
         prev_a_q   <= 32'h0;
         prev_wr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         if (push) wptr_q <= wptr_q + PtrW'(1);
         if (pop)  rptr_q <= rptr_q + PtrW'(1);
         count_q    <= count_d;
         cyc_q      <= cyc_q + 32'h1;
         latch_q    <= latch_d;
         io_rdata_q <= io_rdata_d;
         sel_io_q   <= io_sel;
         full_q     <= (count_d >= CntW'(TX_DEPTH - 2));
         prev_vld_q <= 1'b1;
         prev_a_q   <= cpu_a;
         prev_wr_q  <= cpu_wr;
      end
   end

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed scenarios plus randomized traffic against a queue-based model.
module tb_io_bridge;

   localparam int unsigned TX_DEPTH = 16;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [31:0] cpu_a = 32'h0;
   logic [7:0]  cpu_dout = 8'h00;
   logic        cpu_wr = 1'b0;
   logic [7:0]  cpu_din;
   logic        io_buffer_full;
   logic [16:0] ram_a;
   logic        ram_we;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_pop;
   logic        prog_done;

   io_bridge #(.TX_DEPTH(TX_DEPTH)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_dout(cpu_dout),
      .cpu_wr(cpu_wr), .cpu_din(cpu_din), .io_buffer_full(io_buffer_full),
      .ram_a(ram_a), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop), .prog_done(prog_done)
   );

   always #5 clk_in = ~clk_in;

   // External RAM with one cycle of read latency
   logic [7:0] ram_mem [131072];
   initial for (int i = 0; i < 131072; i++) ram_mem[i] = 8'h00;
   always @(posedge clk_in) begin
      if (ram_we) ram_mem[ram_a] <= ram_dout;
      ram_din <= ram_mem[ram_a];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model state
   logic [7:0]  m_q[$];
   logic [7:0]  m_mem [32];
   bit          m_stop, m_done;
   logic [31:0] m_cnt, m_latch, m_prev_a;
   bit          m_prev_wr, m_prev_vld;
   logic [7:0]  m_rd;
   bit          m_rd_chk;

   // Observations from the last step
   logic [7:0]  tx_seen[$];
   logic [7:0]  obs_din;
   bit          obs_full, obs_valid, obs_done, obs_we;
   int          pops_seen;

   initial for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;

   task automatic model_reset();
      m_q.delete();
      m_stop = 0; m_done = 0;
      m_cnt = 32'h0; m_latch = 32'h0;
      m_prev_vld = 0; m_prev_a = 32'h0; m_prev_wr = 0;
      m_rd = 8'h00; m_rd_chk = 1;
      tx_seen.delete();
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      rx_valid = 1'b1; rx_data = 8'hC3;
      cpu_a = 32'h30000; cpu_wr = 1'b0;
      #1;
      check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
      check_eq("rst_full", 32'(io_buffer_full), 32'h0);
      check_eq("rst_done", 32'(prog_done), 32'h0);
      check_eq("rst_rx_pop", 32'(rx_pop), 32'h0);
      check_eq("rst_cpu_din", 32'(cpu_din), 32'h0);
      repeat (2) @(posedge clk_in);
      #1;
      rx_valid = 1'b0;
      cpu_a = 32'h0;
      rst_in = 1'b0;
      model_reset();
   endtask

   // One bus cycle: drive, check against model at negedge, advance model, end after posedge.
   task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d);
      bit io, newa, pop, room, exp_pop;
      int sz0;
      logic [31:0] src;
      cpu_a = a; cpu_wr = wr; cpu_dout = d;
      @(negedge clk_in);
      io   = (a[17:16] == 2'b11);
      newa = !m_prev_vld || (a != m_prev_a) || (wr != m_prev_wr);
      sz0  = m_q.size();
      check_eq("ram_a", 32'(ram_a), 32'(a[16:0]));
      check_eq("ram_dout", 32'(ram_dout), 32'(d));
      check_eq("ram_we", 32'(ram_we), 32'(wr && !io));
      if (m_rd_chk) check_eq("cpu_din", 32'(cpu_din), 32'(m_rd));
      check_eq("tx_valid", 32'(tx_valid), 32'(sz0 != 0));
      if (sz0 != 0) check_eq("tx_data", 32'(tx_data), 32'(m_q[0]));
      check_eq("io_buffer_full", 32'(io_buffer_full), 32'(sz0 >= int'(TX_DEPTH) - 2));
      check_eq("prog_done", 32'(prog_done), 32'(m_done));
      exp_pop = io && newa && !wr && (a[17:0] == 18'h30000) && rx_valid;
      check_eq("rx_pop", 32'(rx_pop), 32'(exp_pop));
      obs_din = cpu_din; obs_full = io_buffer_full; obs_valid = tx_valid;
      obs_done = prog_done; obs_we = ram_we;
      if (rx_pop) pops_seen++;
      if (tx_valid && tx_ready) tx_seen.push_back(tx_data);
      // Advance the model
      pop = (sz0 != 0) && tx_ready;
      m_rd_chk = 0;
      if (!wr) begin
         m_rd_chk = 1;
         if (!io) begin
            m_rd = m_mem[a[4:0]];
         end else if (a[17:0] == 18'h30000) begin
            m_rd = (newa && rx_valid) ? rx_data : 8'h00;
         end else if (a[17:2] == 16'hC001) begin
            if (newa && a[1:0] == 2'b00) m_latch = m_cnt;
            src = m_latch;
            case (a[1:0])
               2'd0: m_rd = src[7:0];
               2'd1: m_rd = src[15:8];
               2'd2: m_rd = src[23:16];
               default: m_rd = src[31:24];
            endcase
         end else begin
            m_rd = 8'h00;
         end
      end
      if (wr && !io) m_mem[a[4:0]] = d;
      room = (sz0 < int'(TX_DEPTH)) || pop;
      if (pop) void'(m_q.pop_front());
      if (wr && io && newa && !m_stop) begin
         if (a[17:0] == 18'h30000) begin
            if (d != 8'h00 && room) m_q.push_back(d);
         end else if (a[17:0] == 18'h30004) begin
            if (room) m_q.push_back(8'h00);
            m_stop = 1;
         end
      end
      m_cnt = m_cnt + 32'h1;
      m_prev_a = a; m_prev_wr = wr; m_prev_vld = 1;
      if (m_stop && m_q.size() == 0) m_done = 1;
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      step(32'h0, 1'b0, 8'h00);
   endtask

   initial begin
      logic [31:0] la, ra;
      logic        lwr, rwr;
      logic [7:0]  ld, rd;
      logic [7:0]  cbytes[4];
      int          first_idle, first_done, r;

      #2;
      do_reset();

      // RAM write then read back
      step(32'h00010, 1'b1, 8'h12);
      check_eq("ram_we_on_write", 32'(obs_we), 32'h1);
      step(32'h00010, 1'b0, 8'h00);
      check_eq("ram_we_on_read", 32'(obs_we), 32'h0);
      idle();
      check_eq("ram_readback", 32'(obs_din), 32'h12);

      // Held write to TX address yields one byte
      tx_seen.delete();
      tx_ready = 1'b1;
      repeat (3) step(32'h30000, 1'b1, 8'h41);
      repeat (4) idle();
      check_eq("tx_once_count", 32'(tx_seen.size()), 32'd1);
      if (tx_seen.size() > 0) check_eq("tx_once_byte", 32'(tx_seen[0]), 32'h41);

      // RX read held two cycles
      rx_valid = 1'b1; rx_data = 8'h5A; pops_seen = 0;
      step(32'h30000, 1'b0, 8'h00);
      step(32'h30000, 1'b0, 8'h00);
      check_eq("rx_data_read", 32'(obs_din), 32'h5A);
      check_eq("rx_pop_pulses", 32'(pops_seen), 32'd1);
      rx_valid = 1'b0;
      idle();
      step(32'h30000, 1'b0, 8'h00);
      idle();
      check_eq("rx_empty_read", 32'(obs_din), 32'h00);

      // Fill past capacity with the TX side stalled
      do_reset();
      tx_ready = 1'b0;
      for (int k = 1; k <= int'(TX_DEPTH) + 2; k++) begin
         step(32'h30000, 1'b1, 8'(8'h80 + k - 1));
         idle();
         check_eq("full_flag", 32'(obs_full), 32'(k >= int'(TX_DEPTH) - 2));
      end
      tx_ready = 1'b1;
      repeat (TX_DEPTH + 3) idle();
      check_eq("drain_count", 32'(tx_seen.size()), 32'(TX_DEPTH));
      for (int k = 0; k < tx_seen.size(); k++) check_eq("drain_order", 32'(tx_seen[k]), 32'(8'h80 + k));

      // Counter snapshot across the byte lanes
      do_reset();
      while (m_cnt != 32'hFF) idle();
      step(32'h30004, 1'b0, 8'h00);
      for (int k = 1; k < 4; k++) begin
         step(32'h30004 + 32'(k), 1'b0, 8'h00);
         cbytes[k - 1] = obs_din;
      end
      idle();
      cbytes[3] = obs_din;
      check_eq("cnt_b0", 32'(cbytes[0]), 32'hFF);
      check_eq("cnt_b1", 32'(cbytes[1]), 32'h00);
      check_eq("cnt_b2", 32'(cbytes[2]), 32'h00);
      check_eq("cnt_b3", 32'(cbytes[3]), 32'h00);

      // Stop with two bytes queued
      do_reset();
      tx_ready = 1'b0;
      step(32'h30000, 1'b1, 8'h11); idle();
      step(32'h30000, 1'b1, 8'h22); idle();
      step(32'h30004, 1'b1, 8'h00);
      tx_ready = 1'b1;
      first_idle = -1; first_done = -1;
      for (int k = 0; k < 8; k++) begin
         idle();
         if (!obs_valid && first_idle < 0) first_idle = k;
         if (obs_done && first_done < 0) first_done = k;
      end
      check_eq("stop_count", 32'(tx_seen.size()), 32'd3);
      if (tx_seen.size() == 3) begin
         check_eq("stop_b0", 32'(tx_seen[0]), 32'h11);
         check_eq("stop_b1", 32'(tx_seen[1]), 32'h22);
         check_eq("stop_b2", 32'(tx_seen[2]), 32'h00);
      end
      check_eq("done_timing", 32'(first_done), 32'(first_idle));
      step(32'h30000, 1'b1, 8'h55); idle(); idle();
      check_eq("after_done_tx", 32'(tx_seen.size()), 32'd3);
      check_eq("after_done_flag", 32'(obs_done), 32'h1);

      // Reset in the middle of traffic with read data pending
      do_reset();
      tx_ready = 1'b0;
      step(32'h30000, 1'b1, 8'h77); idle();
      rx_valid = 1'b1; rx_data = 8'hA5;
      step(32'h30000, 1'b0, 8'h00);
      do_reset();

      // Randomized traffic
      la = 32'h0; lwr = 1'b0; ld = 8'h00;
      for (int n = 0; n < 3000; n++) begin
         tx_ready = 1'($urandom_range(0, 1));
         rx_valid = 1'($urandom_range(0, 1));
         rx_data  = 8'($urandom);
         r   = $urandom_range(0, 9);
         rwr = 1'($urandom_range(0, 1));
         rd  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         case (r)
            0, 1, 2: ra = 32'($urandom_range(0, 31));
            3, 4:    ra = 32'h30000;
            5:       ra = 32'h30004 + 32'($urandom_range(0, 3));
            6:       ra = ($urandom_range(0, 1) == 0) ? 32'h30008 : 32'h3FFFF;
            7, 8:    begin ra = la; rwr = lwr; rd = ld; end
            default: begin
               if ($urandom_range(0, 59) == 0) begin
                  ra = 32'h30004; rwr = 1'b1;
               end else begin
                  ra = 32'h0; rwr = 1'b0;
               end
            end
         endcase
         step(ra, rwr, rd);
         la = ra; lwr = rwr; ld = rd;
         if (m_done && $urandom_range(0, 19) == 0) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
